// File: rtl/seq_controle_if.sv
// ---------------------------------------------------------------------------
// seq_controle_if
// Instruction handshake between the PS/2 keyboard decoder and the sequencer.
//   instr_valid  decoder -> sequencer  an instruction is present on instr
//   instr[2:0]   decoder -> sequencer  3-bit opcode
//   instr_ready  sequencer -> decoder  FIFO can accept this cycle
// A transfer happens on a rising clock edge where instr_valid and instr_ready
// are both high.
//   master : the instruction source (keyboard decoder, testbench)
//   slave  : the sequencer
// ---------------------------------------------------------------------------
interface seq_controle_if;
    logic       instr_valid;
    logic [2:0] instr;
    logic       instr_ready;

    modport master (
        output instr_valid,
        output instr,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instr,
        output instr_ready
    );
endinterface

// File: rtl/seq_controle.sv
// ---------------------------------------------------------------------------
// seq_controle
// Registered sequencer for the X/Y/Z register + ULA calculator datapath.
// Instructions arrive from the keyboard decoder over a valid/ready handshake
// and are buffered in a 2-entry FIFO. The FSM then executes them one at a
// time, driving the register codes, the ULA operation and a ULA strobe.
//
// Parameters
//   LOAD_CYCLES  cycles tx=load is held for a LOAD instruction (1..15)
//   ALU_LAT      cycles waited after ula_strobe before Y is written (1..15)
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   rst          synchronous, active-high reset
//   bus          instruction handshake (slave side)
//   tx, ty, tz   register codes: 00 clear, 01 load, 10 hold
//   tula         ULA op: 0 add (Y+X), 1 sub (Y-X)
//   ula_strobe   one-cycle pulse, ULA samples its operands
//   busy         FSM is not idle
//   done         one-cycle pulse per retired instruction
//   err          one-cycle pulse with done for an illegal opcode
//   op_count     retired-instruction counter, wraps at 256
//
// Opcodes: 000 CLRLD, 001 ADD, 010 SUB, 011 DISP, 100 LOAD, 101 NOP,
//          11x illegal (retired as a no-op with err).
// ---------------------------------------------------------------------------
module seq_controle #(
    parameter int LOAD_CYCLES = 1,
    parameter int ALU_LAT     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_controle_if.slave        bus,
    output logic [1:0]           tx,
    output logic [1:0]           ty,
    output logic [1:0]           tz,
    output logic                 tula,
    output logic                 ula_strobe,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [7:0]           op_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_CLR    = 3'd2;
    localparam logic [2:0] S_LDX    = 3'd3;
    localparam logic [2:0] S_ALU    = 3'd4;
    localparam logic [2:0] S_WRY    = 3'd5;
    localparam logic [2:0] S_DISP   = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

    localparam logic [1:0] CODE_CLEAR = 2'b00;
    localparam logic [1:0] CODE_LOAD  = 2'b01;
    localparam logic [1:0] CODE_HOLD  = 2'b10;

    // Wait counters count down to zero, so they start at length-1.
    localparam logic [3:0] LOAD_INIT = 4'(LOAD_CYCLES - 1);
    localparam logic [3:0] ALU_INIT  = 4'(ALU_LAT - 1);

    logic [2:0] state;
    logic [2:0] opcode;
    logic       illegal;
    logic [3:0] cnt;

    logic [2:0] fifo_mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] fifo_count;

    logic       push;
    logic       pop;

    // Ready is forced low during reset so nothing is accepted into a FIFO
    // that is being flushed in the same cycle.
    assign bus.instr_ready = !rst && (fifo_count != 2'd2);
    assign push = bus.instr_valid && bus.instr_ready;
    assign pop  = (state == S_IDLE) && (fifo_count != 2'd0);

    // Two-entry instruction FIFO. Pushing and popping together leaves the
    // count unchanged; a push is never attempted while full because ready
    // is low then.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= bus.instr;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Sequencer FSM. The opcode is latched at pop, decoded for one cycle,
    // and every instruction path funnels through S_DONE so that done,
    // err and op_count are produced in exactly one place.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            opcode   <= 3'b000;
            illegal  <= 1'b0;
            cnt      <= 4'd0;
            tula     <= 1'b0;
            op_count <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        opcode <= fifo_mem[rd_ptr];
                        state  <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    illegal <= (opcode[2:1] == 2'b11);
                    case (opcode)
                        3'b000: state <= S_CLR;
                        3'b100: begin
                            cnt   <= LOAD_INIT;
                            state <= S_LDX;
                        end
                        3'b001, 3'b010: begin
                            cnt   <= ALU_INIT;
                            tula  <= opcode[1];
                            state <= S_ALU;
                        end
                        3'b011: state <= S_DISP;
                        default: state <= S_DONE;
                    endcase
                end
                S_LDX: begin
                    if (cnt == 4'd0) begin
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_ALU: begin
                    if (cnt == 4'd0) begin
                        state <= S_WRY;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_CLR, S_WRY, S_DISP: begin
                    state <= S_DONE;
                end
                S_DONE: begin
                    op_count <= op_count + 8'd1;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Output decode from the registered state. The strobe marks the first
    // ALU cycle, recognised by the counter still holding its start value.
    always_comb begin
        tx         = CODE_HOLD;
        ty         = CODE_HOLD;
        tz         = CODE_HOLD;
        ula_strobe = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        busy       = (state != S_IDLE);
        case (state)
            S_CLR: begin
                tx = CODE_CLEAR;
                ty = CODE_CLEAR;
                tz = CODE_CLEAR;
            end
            S_LDX:  tx = CODE_LOAD;
            S_ALU:  ula_strobe = (cnt == ALU_INIT);
            S_WRY: begin
                ty = CODE_LOAD;
                tx = CODE_CLEAR;
            end
            S_DISP: tz = CODE_LOAD;
            S_DONE: begin
                done = 1'b1;
                err  = illegal;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_seq_controle.sv
// ---------------------------------------------------------------------------
// tb_seq_controle
// Directed testbench for seq_controle with LOAD_CYCLES=3 and ALU_LAT=2.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_seq_controle;

    localparam logic [2:0] OP_CLRLD = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b001;
    localparam logic [2:0] OP_SUB   = 3'b010;
    localparam logic [2:0] OP_DISP  = 3'b011;
    localparam logic [2:0] OP_LOAD  = 3'b100;
    localparam logic [2:0] OP_NOP   = 3'b101;
    localparam logic [2:0] OP_ILL   = 3'b110;

    // {tx,ty,tz} patterns
    localparam logic [5:0] C_HOLD = 6'b10_10_10;
    localparam logic [5:0] C_CLR  = 6'b00_00_00;
    localparam logic [5:0] C_LDX  = 6'b01_10_10;
    localparam logic [5:0] C_WRY  = 6'b00_01_10;
    localparam logic [5:0] C_DISP = 6'b10_10_01;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] tx, ty, tz;
    logic       tula, ula_strobe, busy, done, err;
    logic [7:0] op_count;

    int compares   = 0;
    int mismatches = 0;
    int done_total = 0;
    logic rec = 1'b0;
    int seq_code = 0;
    int last_val = 0;

    seq_controle_if bus ();

    seq_controle #(.LOAD_CYCLES(3), .ALU_LAT(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .tx         (tx),
        .ty         (ty),
        .tz         (tz),
        .tula       (tula),
        .ula_strobe (ula_strobe),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] codes();
        return {tx, ty, tz};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compares++;
        if (obs !== exp) begin
            mismatches++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Presents one instruction for a single rising edge; returns at the
    // falling edge right after the acceptance edge.
    task automatic applyStimulus(input logic [2:0] op);
        checkOutput("push_ready", 32'(bus.instr_ready), 32'd1);
        bus.instr_valid = 1'b1;
        bus.instr       = op;
        @(negedge clk);
        bus.instr_valid = 1'b0;
    endtask

    // Counts done pulses and, while rec is set, builds an ordered trace of
    // the distinct control activities seen (one octal digit each).
    always @(negedge clk) begin
        int v;
        if (done) done_total++;
        if (rec) begin
            v = 0;
            if (ula_strobe)           v = 4;
            else if (codes() == C_CLR)  v = 1;
            else if (codes() == C_LDX)  v = 2;
            else if (codes() == C_DISP) v = 3;
            else if (codes() == C_WRY)  v = 5;
            if (v != 0 && v != last_val) seq_code = seq_code * 8 + v;
            last_val = v;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        mismatches++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
        $finish;
    end

    initial begin
        int held;
        int d0;
        int nop_ok;
        bit got;

        rst             = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr       = 3'b000;
        repeat (2) @(negedge clk);

        // Reset state
        checkOutput("rst_busy",   32'(busy), 32'd0);
        checkOutput("rst_codes",  32'(codes()), 32'(C_HOLD));
        checkOutput("rst_done",   32'(done), 32'd0);
        checkOutput("rst_err",    32'(err), 32'd0);
        checkOutput("rst_strobe", 32'(ula_strobe), 32'd0);
        checkOutput("rst_tula",   32'(tula), 32'd0);
        checkOutput("rst_count",  32'(op_count), 32'd0);
        checkOutput("rst_ready",  32'(bus.instr_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_ready", 32'(bus.instr_ready), 32'd1);

        // Test 1: reset in the first ALU cycle with two instructions queued
        applyStimulus(OP_ADD);
        applyStimulus(OP_CLRLD);
        applyStimulus(OP_DISP);
        checkOutput("t1_in_alu_strobe", 32'(ula_strobe), 32'd1);
        checkOutput("t1_full_ready",    32'(bus.instr_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t1_busy",  32'(busy), 32'd0);
        checkOutput("t1_codes", 32'(codes()), 32'(C_HOLD));
        checkOutput("t1_count", 32'(op_count), 32'd0);
        checkOutput("t1_done",  32'(done), 32'd0);
        checkOutput("t1_strobe", 32'(ula_strobe), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t1_ready_after", 32'(bus.instr_ready), 32'd1);
        checkOutput("t1_empty_busy0", 32'(busy), 32'd0);
        @(negedge clk);
        checkOutput("t1_empty_busy1", 32'(busy), 32'd0);
        checkOutput("t1_empty_done",  32'(done), 32'd0);

        // Test 2: LOAD, tx=01 for three cycles starting two cycles after acceptance
        applyStimulus(OP_LOAD);
        checkOutput("t2_idle_busy", 32'(busy), 32'd0);
        @(negedge clk);
        checkOutput("t2_decode_busy",  32'(busy), 32'd1);
        checkOutput("t2_decode_codes", 32'(codes()), 32'(C_HOLD));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("t2_ldx_codes", 32'(codes()), 32'(C_LDX));
            checkOutput("t2_ldx_done",  32'(done), 32'd0);
        end
        @(negedge clk);
        checkOutput("t2_done",       32'(done), 32'd1);
        checkOutput("t2_err",        32'(err), 32'd0);
        checkOutput("t2_done_codes", 32'(codes()), 32'(C_HOLD));
        checkOutput("t2_count_pre",  32'(op_count), 32'd0);
        @(negedge clk);
        checkOutput("t2_done_clear", 32'(done), 32'd0);
        checkOutput("t2_count",      32'(op_count), 32'd1);
        checkOutput("t2_busy_end",   32'(busy), 32'd0);

        // Test 3: SUB with a two-cycle ALU wait
        applyStimulus(OP_SUB);
        @(negedge clk);
        checkOutput("t3_decode_strobe", 32'(ula_strobe), 32'd0);
        @(negedge clk);
        checkOutput("t3_strobe1", 32'(ula_strobe), 32'd1);
        checkOutput("t3_tula",    32'(tula), 32'd1);
        checkOutput("t3_alu_codes1", 32'(codes()), 32'(C_HOLD));
        @(negedge clk);
        checkOutput("t3_strobe2", 32'(ula_strobe), 32'd0);
        checkOutput("t3_alu_codes2", 32'(codes()), 32'(C_HOLD));
        @(negedge clk);
        checkOutput("t3_wry_codes", 32'(codes()), 32'(C_WRY));
        checkOutput("t3_wry_done",  32'(done), 32'd0);
        @(negedge clk);
        checkOutput("t3_done",      32'(done), 32'd1);
        checkOutput("t3_done_codes", 32'(codes()), 32'(C_HOLD));
        @(negedge clk);
        checkOutput("t3_count",     32'(op_count), 32'd2);
        checkOutput("t3_tula_held", 32'(tula), 32'd1);

        // Test 5: illegal opcode 110
        applyStimulus(OP_ILL);
        @(negedge clk);
        checkOutput("t5_decode_codes", 32'(codes()), 32'(C_HOLD));
        checkOutput("t5_decode_err",   32'(err), 32'd0);
        @(negedge clk);
        checkOutput("t5_done",   32'(done), 32'd1);
        checkOutput("t5_err",    32'(err), 32'd1);
        checkOutput("t5_codes",  32'(codes()), 32'(C_HOLD));
        checkOutput("t5_strobe", 32'(ula_strobe), 32'd0);
        @(negedge clk);
        checkOutput("t5_err_clear", 32'(err), 32'd0);
        checkOutput("t5_count",     32'(op_count), 32'd3);

        // Test 4: LOAD keeps the FSM busy, then CLRLD and DISP fill the FIFO
        // and ADD must wait for space
        seq_code = 0;
        last_val = 0;
        rec      = 1'b1;
        d0       = done_total;
        applyStimulus(OP_LOAD);
        applyStimulus(OP_CLRLD);
        applyStimulus(OP_DISP);
        checkOutput("t4_full_ready", 32'(bus.instr_ready), 32'd0);
        bus.instr_valid = 1'b1;
        bus.instr       = OP_ADD;
        held = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.instr_ready) break;
            held++;
            @(negedge clk);
        end
        checkOutput("t4_add_held", 32'(held >= 2 && held < 40), 32'd1);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        repeat (40) @(negedge clk);
        rec = 1'b0;
        #1;
        checkOutput("t4_order",  32'(seq_code), 32'o21345);
        checkOutput("t4_dones",  32'(done_total - d0), 32'd4);
        checkOutput("t4_count",  32'(op_count), 32'd7);
        checkOutput("t4_tula",   32'(tula), 32'd0);
        checkOutput("t4_idle",   32'(busy), 32'd0);

        // Test 6: 256 NOPs wrap op_count
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        d0     = done_total;
        nop_ok = 0;
        @(negedge clk);
        for (int n = 0; n < 256; n++) begin
            applyStimulus(OP_NOP);
            got = 1'b0;
            for (int i = 0; i < 10; i++) begin
                if (done) begin
                    got = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            if (got) nop_ok++;
            @(negedge clk);
            if (n == 254) checkOutput("t6_count_255", 32'(op_count), 32'd255);
        end
        #1;
        checkOutput("t6_nops_done", 32'(nop_ok), 32'd256);
        checkOutput("t6_pulses",    32'(done_total - d0), 32'd256);
        checkOutput("t6_wrap",      32'(op_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
        $finish;
    end

endmodule
